rv32i_multicycle_ctrl: RTL
==========================

# rv32i_multicycle_ctrl

Multi-cycle sequencer for the RV32I core. It fetches an instruction into its own instruction register and decodes the opcode. It then steps the shared datapath (immediate generator, ALU, register file, PC, memory port) through fetch, decode, execute, memory and writeback, asserting one set of select/enable lines per state. It drives the immediate generator's `imm_mux` select and its `instr[31:7]` source (`ir_q`). It replaces per-instruction hardwired control with a single FSM.

## Interface
- No parameters; XLEN fixed at 32.
- `clk`  in  1  rising-edge clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `instr`  in  32  memory read data; sampled as an instruction in FETCH.
- `mem_ready`  in  1  memory handshake; ignored outside FETCH and MEM.
- `br_taken`  in  1  ALU compare result; sampled only in EXEC for BRANCH.
- `ir_q`  out  32  instruction register; bits [31:7] feed the immediate generator.
- `imm_mux`  out  3  immediate-format select, using the `Def.v` macros.
- `mem_req`  out  1  memory request.
- `mem_addr_sel`  out  1  0 = PC, 1 = ALU result.
- `mem_we`  out  1  store strobe, qualified by `mem_req`.
- `alu_a_sel`  out  1  0 = rs1, 1 = PC.
- `alu_b_sel`  out  1  0 = rs2, 1 = imm.
- `alu_op`  out  2  00 = add, 01 = funct3/funct7 decoded, 10 = branch compare.
- `pc_we`  out  1  PC update enable.
- `pc_sel`  out  2  00 = PC+4, 01 = ALU result, 10 = ALU result & ~1.
- `rf_we`  out  1  register-file write enable.
- `wb_sel`  out  2  00 = ALU, 01 = mem data, 10 = PC+4, 11 = imm.
- `halted`  out  1  sticky; set on ECALL/EBREAK or an illegal opcode.
- `illegal`  out  1  sticky; set on an illegal opcode.
- `state_q`  out  3  FSM state, for debug.

## Operation
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Encodings 6–7 return to FETCH on the next clock.
- **FETCH**
  - Outputs: `mem_req`=1, `mem_addr_sel`=0.
  - If `mem_ready`: load `ir_q`<=`instr`, go to DECODE. Otherwise hold.
- **DECODE**
  - Decode opcode = `ir_q[6:0]`.
  - Legal opcodes go to EXEC.
  - SYSTEM (1110011) goes to HALT with `halted`=1.
  - Any unlisted opcode goes to HALT with `halted`=1 and `illegal`=1.
- **`imm_mux` mapping** (combinational from `ir_q`, valid from DECODE onward):
  - OP-IMM (0010011) and JALR (1100111) → I_type.
  - LOAD (0000011) → I_type_load.
  - STORE (0100011) → S_type.
  - BRANCH (1100011) → B_type.
  - JAL (1101111) → J_type.
  - LUI (0110111) → U_type_LUI.
  - AUIPC (0010111) → U_type_AUIPC.
  - All other opcodes → I_type.
- **EXEC**
  - OP (0110011): a=rs1, b=rs2, `alu_op`=01. Go to WB.
  - OP-IMM: a=rs1, b=imm, `alu_op`=01. Go to WB.
  - LOAD/STORE: a=rs1, b=imm, `alu_op`=00. Go to MEM.
  - AUIPC and JAL: a=PC, b=imm, `alu_op`=00. Go to WB.
  - JALR: a=rs1, b=imm, `alu_op`=00. Go to WB.
  - LUI: go to WB; the ALU is unused.
  - BRANCH: a=rs1, b=rs2, `alu_op`=10, `pc_we`=1. `pc_sel`=01 if `br_taken`, else 00. Go to FETCH.
  - BRANCH target is precomputed by the datapath adder; the ALU result port carries the target when `alu_op`=10.
  - FENCE (0001111): `pc_we`=1, `pc_sel`=00. Go to FETCH (executes as a NOP).
- **MEM**
  - Outputs: `mem_req`=1, `mem_addr_sel`=1, `mem_we`=1 for STORE only.
  - Hold until `mem_ready`.
  - LOAD then goes to WB.
  - STORE then pulses `pc_we`=1 with `pc_sel`=00 in that same cycle and goes to FETCH.
- **WB**
  - `rf_we`=1 and `pc_we`=1 for one cycle, then go to FETCH.
  - JAL: `wb_sel`=10, `pc_sel`=01.
  - JALR: `wb_sel`=10, `pc_sel`=10.
  - LUI: `wb_sel`=11.
  - LOAD: `wb_sel`=01.
  - All other WB instructions: `wb_sel`=00, `pc_sel`=00.
- **HALT**: absorbing state. All enables stay 0. Only `rst` leaves it.
- Any output not named for a state is 0 in that state.

## Timing
- State, `ir_q`, `halted` and `illegal` are registered. All other outputs are combinational from `state_q` and `ir_q`.
- Reset values: `state_q`=FETCH, `ir_q`=0, `halted`=0, `illegal`=0.
- After reset, FETCH asserts `mem_req`=1 in the first cycle.
- Cycles per instruction with `mem_ready` high every cycle:
  - BRANCH and FENCE: 3.
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR and STORE: 4.
  - LOAD: 5.
- Each wait-state cycle (`mem_ready`=0) in FETCH or MEM adds one cycle. Outputs are held stable while waiting.
- `rst` asserted in any state:
  - Next edge: FETCH, with reset values as above.
  - An in-flight memory response is dropped. `mem_req` may fall before `mem_ready`.
- `rst` and `mem_ready` in the same cycle: reset wins; `ir_q` is not loaded.
- `pc_we` and `rf_we` are never asserted in FETCH, DECODE or HALT.

## Test plan
- **ADDI**: `instr`=0x00500093 (addi x1,x0,5), `mem_ready`=1 → states 0,1,2,4,0. `imm_mux`=I_type. `alu_b_sel`=1. `rf_we`=1 and `pc_we`=1 only in the WB cycle.
- **LW with wait states**: 0x0000A103 (lw x2,0(x1)), `mem_ready` low for 2 cycles in MEM → MEM lasts 3 cycles with `mem_req`=1, `mem_addr_sel`=1, `mem_we`=0 held. WB has `wb_sel`=01. Total 7 cycles.
- **Branch both ways**: 0x00208463 (beq) with `br_taken`=1 → EXEC has `pc_sel`=01, `pc_we`=1, then FETCH. Same instruction with `br_taken`=0 → `pc_sel`=00. `rf_we` never set. `imm_mux`=B_type.
- **Jumps**:
  - JAL 0x008000EF → `imm_mux`=J_type; WB `wb_sel`=10, `pc_sel`=01.
  - JALR 0x000080E7 → WB `pc_sel`=10.
- **Illegal and SYSTEM**:
  - `instr`=0xFFFFFFFF → HALT. `halted`=1 and `illegal`=1 held for 10 cycles; all enables 0.
  - ECALL 0x00000073 → `halted`=1, `illegal`=0.
- **Reset mid-operation**: `rst` pulsed during MEM of an SW (0x0020A023) → next cycle `state_q`=0, `ir_q`=0, `mem_we`=0. `mem_ready` arriving with `rst` is ignored.

Source files
------------

// File: rtl/rv32i_multicycle_ctrl_if.sv
// Bundle between the multi-cycle controller and the shared datapath/memory.
//   master (controller): samples instr/mem_ready/br_taken, drives IR,
//                        immediate select, datapath enables and status.
//   slave  (datapath)  : the mirror image.
interface rv32i_multicycle_ctrl_if;
  logic [31:0] instr;
  logic        mem_ready;
  logic        br_taken;
  logic [31:0] ir_q;
  logic [2:0]  imm_mux;
  logic        mem_req;
  logic        mem_addr_sel;
  logic        mem_we;
  logic        alu_a_sel;
  logic        alu_b_sel;
  logic [1:0]  alu_op;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic        halted;
  logic        illegal;
  logic [2:0]  state_q;

  modport master (
    input  instr, mem_ready, br_taken,
    output ir_q, imm_mux, mem_req, mem_addr_sel, mem_we, alu_a_sel, alu_b_sel,
           alu_op, pc_we, pc_sel, rf_we, wb_sel, halted, illegal, state_q
  );

  modport slave (
    output instr, mem_ready, br_taken,
    input  ir_q, imm_mux, mem_req, mem_addr_sel, mem_we, alu_a_sel, alu_b_sel,
           alu_op, pc_we, pc_sel, rf_we, wb_sel, halted, illegal, state_q
  );
endinterface

// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// Holds the instruction register, decodes the opcode and drives one set of
// datapath selects/enables per state.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : controller side of rv32i_multicycle_ctrl_if
//         in : instr, mem_ready, br_taken
//         out: ir_q, imm_mux, mem_req, mem_addr_sel, mem_we, alu_a_sel,
//              alu_b_sel, alu_op, pc_we, pc_sel, rf_we, wb_sel, halted,
//              illegal, state_q
// State, ir_q, halted and illegal are registered; every other output is
// decoded combinationally from the state and ir_q (plus br_taken/mem_ready
// where a decision depends on them).
module rv32i_multicycle_ctrl (
  input logic                          clk,
  input logic                          rst,
  rv32i_multicycle_ctrl_if.master      bus
);

  // Immediate-format codes (values of the Def.v macros)
  localparam logic [2:0] I_TYPE       = 3'd0;
  localparam logic [2:0] S_TYPE       = 3'd1;
  localparam logic [2:0] B_TYPE       = 3'd2;
  localparam logic [2:0] U_TYPE_LUI   = 3'd3;
  localparam logic [2:0] U_TYPE_AUIPC = 3'd4;
  localparam logic [2:0] J_TYPE       = 3'd5;
  localparam logic [2:0] I_TYPE_LOAD  = 3'd6;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t      r_state;
  logic [31:0] r_ir;
  logic        r_halted;
  logic        r_illegal;

  logic [6:0]  w_opc;
  logic        w_is_op, w_is_opimm, w_is_load, w_is_store, w_is_branch;
  logic        w_is_jal, w_is_jalr, w_is_lui, w_is_auipc, w_is_fence, w_is_system;
  logic        w_legal;
  logic [2:0]  w_imm_mux;

  assign w_opc = r_ir[6:0];

  always_comb begin
    w_is_op     = 1'b0;
    w_is_opimm  = 1'b0;
    w_is_load   = 1'b0;
    w_is_store  = 1'b0;
    w_is_branch = 1'b0;
    w_is_jal    = 1'b0;
    w_is_jalr   = 1'b0;
    w_is_lui    = 1'b0;
    w_is_auipc  = 1'b0;
    w_is_fence  = 1'b0;
    w_is_system = 1'b0;
    w_imm_mux   = I_TYPE;
    case (w_opc)
      OPC_OP:     w_is_op = 1'b1;
      OPC_OPIMM:  w_is_opimm = 1'b1;
      OPC_LOAD:   begin w_is_load   = 1'b1; w_imm_mux = I_TYPE_LOAD;  end
      OPC_STORE:  begin w_is_store  = 1'b1; w_imm_mux = S_TYPE;       end
      OPC_BRANCH: begin w_is_branch = 1'b1; w_imm_mux = B_TYPE;       end
      OPC_JAL:    begin w_is_jal    = 1'b1; w_imm_mux = J_TYPE;       end
      OPC_JALR:   w_is_jalr = 1'b1;
      OPC_LUI:    begin w_is_lui    = 1'b1; w_imm_mux = U_TYPE_LUI;   end
      OPC_AUIPC:  begin w_is_auipc  = 1'b1; w_imm_mux = U_TYPE_AUIPC; end
      OPC_FENCE:  w_is_fence = 1'b1;
      OPC_SYSTEM: w_is_system = 1'b1;
      default:    ;
    endcase
  end

  assign w_legal = w_is_op | w_is_opimm | w_is_load | w_is_store | w_is_branch |
                   w_is_jal | w_is_jalr | w_is_lui | w_is_auipc | w_is_fence;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_ir      <= '0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (bus.mem_ready) begin
            r_ir    <= bus.instr;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (w_legal) begin
            r_state <= S_EXEC;
          end else begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
            if (!w_is_system) r_illegal <= 1'b1;
          end
        end
        S_EXEC: begin
          if (w_is_load || w_is_store)        r_state <= S_MEM;
          else if (w_is_branch || w_is_fence) r_state <= S_FETCH;
          else                                r_state <= S_WB;
        end
        S_MEM: begin
          if (bus.mem_ready) r_state <= w_is_load ? S_WB : S_FETCH;
        end
        S_WB:    r_state <= S_FETCH;
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  logic       w_mem_req, w_mem_addr_sel, w_mem_we, w_alu_a_sel, w_alu_b_sel;
  logic [1:0] w_alu_op, w_pc_sel, w_wb_sel;
  logic       w_pc_we, w_rf_we;

  always_comb begin
    w_mem_req      = 1'b0;
    w_mem_addr_sel = 1'b0;
    w_mem_we       = 1'b0;
    w_alu_a_sel    = 1'b0;
    w_alu_b_sel    = 1'b0;
    w_alu_op       = 2'b00;
    w_pc_we        = 1'b0;
    w_pc_sel       = 2'b00;
    w_rf_we        = 1'b0;
    w_wb_sel       = 2'b00;
    case (r_state)
      S_FETCH: w_mem_req = 1'b1;
      S_EXEC: begin
        if (w_is_op) w_alu_op = 2'b01;
        if (w_is_opimm) begin
          w_alu_b_sel = 1'b1;
          w_alu_op    = 2'b01;
        end
        if (w_is_load || w_is_store || w_is_jalr) w_alu_b_sel = 1'b1;
        if (w_is_auipc || w_is_jal) begin
          w_alu_a_sel = 1'b1;
          w_alu_b_sel = 1'b1;
        end
        if (w_is_branch) begin
          w_alu_op = 2'b10;
          w_pc_we  = 1'b1;
          w_pc_sel = bus.br_taken ? 2'b01 : 2'b00;
        end
        if (w_is_fence) w_pc_we = 1'b1;
      end
      S_MEM: begin
        w_mem_req      = 1'b1;
        w_mem_addr_sel = 1'b1;
        w_mem_we       = w_is_store;
        // a store retires in the cycle its memory handshake completes
        w_pc_we        = w_is_store & bus.mem_ready;
      end
      S_WB: begin
        w_rf_we = 1'b1;
        w_pc_we = 1'b1;
        if (w_is_jal) begin
          w_wb_sel = 2'b10;
          w_pc_sel = 2'b01;
        end else if (w_is_jalr) begin
          w_wb_sel = 2'b10;
          w_pc_sel = 2'b10;
        end else if (w_is_lui) begin
          w_wb_sel = 2'b11;
        end else if (w_is_load) begin
          w_wb_sel = 2'b01;
        end
      end
      default: ;
    endcase
  end

  assign bus.ir_q         = r_ir;
  assign bus.imm_mux      = w_imm_mux;
  assign bus.mem_req      = w_mem_req;
  assign bus.mem_addr_sel = w_mem_addr_sel;
  assign bus.mem_we       = w_mem_we;
  assign bus.alu_a_sel    = w_alu_a_sel;
  assign bus.alu_b_sel    = w_alu_b_sel;
  assign bus.alu_op       = w_alu_op;
  assign bus.pc_we        = w_pc_we;
  assign bus.pc_sel       = w_pc_sel;
  assign bus.rf_we        = w_rf_we;
  assign bus.wb_sel       = w_wb_sel;
  assign bus.halted       = r_halted;
  assign bus.illegal      = r_illegal;
  assign bus.state_q      = r_state;

endmodule
